// File: rtl/hit_judge.sv
// Hit judge: debounces pad buttons, judges presses against lane arrows and
// serialises the resulting hit/miss events into separated pulses for score.
module hit_judge #(
  parameter int                  NUM_LANES       = 4,
  parameter int                  DEBOUNCE_CYCLES = 500000,
  parameter int                  PULSE_CYCLES    = 2,
  parameter int                  GAP_CYCLES      = 2,
  parameter int                  PEND_BITS       = 4,
  parameter int                  STATE_BITS      = 2,
  parameter logic [STATE_BITS:0] STATE_RESET     = 3'd0,
  parameter logic [STATE_BITS:0] STATE_GAME      = 3'd2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [STATE_BITS:0]   state,
  input  logic [NUM_LANES-1:0]  buttons,
  input  logic [NUM_LANES-1:0]  arrow_in_zone,
  input  logic [NUM_LANES-1:0]  arrow_passed,
  output logic [NUM_LANES-1:0]  arrow_clear,
  output logic                  correctHit,
  output logic                  incorrectHit,
  output logic                  overflow
);

  localparam int DBW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PH_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int PHW    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int CNTW   = $clog2(NUM_LANES + 1);
  localparam int SW     = PEND_BITS + CNTW + 1;

  localparam logic [DBW-1:0]       DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PHW-1:0]       PULSE_LAST = PHW'(PULSE_CYCLES - 1);
  localparam logic [PHW-1:0]       GAP_LAST   = PHW'(GAP_CYCLES - 1);
  localparam logic [PEND_BITS-1:0] PEND_MAX   = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, GAP = 2'd2} fsm_t;

  function automatic logic [CNTW-1:0] popcount(input logic [NUM_LANES-1:0] v);
    logic [CNTW-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_LANES; i++) n = n + CNTW'(v[i]);
    return n;
  endfunction

  // Returns {saturated, next_count}; decrement is only requested when cur > 0.
  function automatic logic [PEND_BITS:0] pend_next(input logic [PEND_BITS-1:0] cur,
                                                   input logic [CNTW-1:0] add,
                                                   input logic dec);
    logic [SW-1:0] sum;
    sum = SW'(cur) + SW'(add) - SW'(dec);
    if (sum > SW'(PEND_MAX)) return {1'b1, PEND_MAX};
    else                     return {1'b0, sum[PEND_BITS-1:0]};
  endfunction

  logic [NUM_LANES-1:0] sync1_r, sync2_r, stable_r, press_r;
  logic [DBW-1:0]       db_cnt_r [NUM_LANES];
  logic [NUM_LANES-1:0] hit_s, miss_s, clear_r;
  logic [CNTW-1:0]      new_c_s, new_i_s;
  logic [PEND_BITS-1:0] pend_c_r, pend_i_r;
  logic [PEND_BITS:0]   pc_nx_s, pi_nx_s;
  logic                 ovf_r, in_game_s, in_reset_s;
  fsm_t                 fsm_r, fsm_n_s;
  logic [PHW-1:0]       ph_r, ph_n_s;
  logic                 chit_r, ihit_r, chit_n_s, ihit_n_s, dec_c_s, dec_i_s;

  // Synchronizer, debounce counters and press edge detection per lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r  <= '0;
      sync2_r  <= '0;
      stable_r <= '0;
      press_r  <= '0;
      for (int i = 0; i < NUM_LANES; i++) db_cnt_r[i] <= '0;
    end else begin
      sync1_r <= buttons;
      sync2_r <= sync1_r;
      press_r <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (sync2_r[i] != stable_r[i]) begin
          if (db_cnt_r[i] == DB_LAST) begin
            db_cnt_r[i] <= '0;
            stable_r[i] <= sync2_r[i];
            press_r[i]  <= sync2_r[i];
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + 1'b1;
          end
        end else begin
          db_cnt_r[i] <= '0;
        end
      end
    end
  end

  assign in_game_s  = (state == STATE_GAME);
  assign in_reset_s = (state == STATE_RESET);
  // A hit on a lane suppresses the pass-miss of that same lane.
  assign hit_s   = press_r & arrow_in_zone & {NUM_LANES{in_game_s}};
  assign miss_s  = ((press_r & ~arrow_in_zone) | (arrow_passed & ~(press_r & arrow_in_zone)))
                   & {NUM_LANES{in_game_s}};
  assign new_c_s = popcount(hit_s);
  assign new_i_s = popcount(miss_s);
  assign pc_nx_s = pend_next(pend_c_r, new_c_s, dec_c_s);
  assign pi_nx_s = pend_next(pend_i_r, new_i_s, dec_i_s);

  // Pending counters, sticky overflow and arrow removal strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_c_r <= '0;
      pend_i_r <= '0;
      ovf_r    <= 1'b0;
      clear_r  <= '0;
    end else if (in_reset_s) begin
      pend_c_r <= '0;
      pend_i_r <= '0;
      ovf_r    <= 1'b0;
      clear_r  <= '0;
    end else begin
      pend_c_r <= pc_nx_s[PEND_BITS-1:0];
      pend_i_r <= pi_nx_s[PEND_BITS-1:0];
      ovf_r    <= ovf_r | pc_nx_s[PEND_BITS] | pi_nx_s[PEND_BITS];
      clear_r  <= hit_s;
    end
  end

  // Output FSM state and registered pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r  <= IDLE;
      ph_r   <= '0;
      chit_r <= 1'b0;
      ihit_r <= 1'b0;
    end else begin
      fsm_r  <= fsm_n_s;
      ph_r   <= ph_n_s;
      chit_r <= chit_n_s;
      ihit_r <= ihit_n_s;
    end
  end

  // Next-state logic: misses drain before hits, each pulse followed by a gap
  always_comb begin
    fsm_n_s  = fsm_r;
    ph_n_s   = ph_r;
    chit_n_s = 1'b0;
    ihit_n_s = 1'b0;
    dec_c_s  = 1'b0;
    dec_i_s  = 1'b0;
    if (in_reset_s) begin
      fsm_n_s = IDLE;
      ph_n_s  = '0;
    end else begin
      case (fsm_r)
        IDLE: begin
          ph_n_s = '0;
          if (pend_i_r != '0) begin
            dec_i_s  = 1'b1;
            ihit_n_s = 1'b1;
            fsm_n_s  = HIGH;
          end else if (pend_c_r != '0) begin
            dec_c_s  = 1'b1;
            chit_n_s = 1'b1;
            fsm_n_s  = HIGH;
          end else begin
            fsm_n_s = IDLE;
          end
        end
        HIGH: begin
          if (ph_r == PULSE_LAST) begin
            ph_n_s  = '0;
            fsm_n_s = GAP;
          end else begin
            ph_n_s   = ph_r + 1'b1;
            chit_n_s = chit_r;
            ihit_n_s = ihit_r;
          end
        end
        GAP: begin
          if (ph_r == GAP_LAST) begin
            ph_n_s  = '0;
            fsm_n_s = IDLE;
          end else begin
            ph_n_s = ph_r + 1'b1;
          end
        end
        default: begin
          fsm_n_s = IDLE;
          ph_n_s  = '0;
        end
      endcase
    end
  end

  assign arrow_clear  = clear_r;
  assign correctHit   = chit_r;
  assign incorrectHit = ihit_r;
  assign overflow     = ovf_r;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge with a short debounce window; a negedge
// monitor counts pulses, their order and their high/low shape.
module tb_hit_judge;

  localparam logic [2:0] ST_RESET = 3'd0;
  localparam logic [2:0] ST_MENU  = 3'd1;
  localparam logic [2:0] ST_GAME  = 3'd2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] state = ST_MENU;
  logic [3:0] buttons = 4'd0, arrow_in_zone = 4'd0, arrow_passed = 4'd0;
  logic [3:0] arrow_clear;
  logic       correctHit, incorrectHit, overflow;

  int total = 0;
  int bad = 0;
  int c_cnt = 0, i_cnt = 0, clr_cnt = 0, shape_err = 0;
  int hi_len = 0, lo_len = 100;
  logic [3:0] clr_val = 4'd0;
  logic prev = 1'b0;
  int seq[$];
  int b_c, b_i, b_clr, b_shape, bs, ord;

  hit_judge #(
    .NUM_LANES(4), .DEBOUNCE_CYCLES(4), .PULSE_CYCLES(2), .GAP_CYCLES(2),
    .PEND_BITS(4), .STATE_BITS(2), .STATE_RESET(ST_RESET), .STATE_GAME(ST_GAME)
  ) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .buttons(buttons),
    .arrow_in_zone(arrow_in_zone), .arrow_passed(arrow_passed),
    .arrow_clear(arrow_clear), .correctHit(correctHit),
    .incorrectHit(incorrectHit), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts rises, records order, flags bad widths/gaps/overlap
  always @(negedge clk) begin
    if (!rst_n) begin
      prev   = 1'b0;
      hi_len = 0;
      lo_len = 100;
    end else begin
      if (correctHit && incorrectHit) shape_err++;
      if (arrow_clear != 4'd0) begin
        clr_cnt++;
        clr_val = clr_val | arrow_clear;
      end
      if ((correctHit || incorrectHit) && !prev) begin
        if (lo_len < 2) shape_err++;
        if (correctHit) begin c_cnt++; seq.push_back(0); end
        else begin i_cnt++; seq.push_back(1); end
        hi_len = 1;
      end else if (correctHit || incorrectHit) begin
        hi_len++;
      end else if (prev) begin
        if (hi_len != 2) shape_err++;
        lo_len = 1;
      end else begin
        lo_len++;
      end
      prev = correctHit || incorrectHit;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_correct", int'(correctHit), 0);
    chk("rst_incorrect", int'(incorrectHit), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_clear", int'(arrow_clear), 0);
    rst_n = 1'b1;
    tick(5);

    // Lane-0 hit: press pulse 6 cycles after the raw edge, clear one later, pulse one after that
    state = ST_GAME; arrow_in_zone = 4'b0001; buttons = 4'b0001;
    tick(7);
    chk("hit_clear", int'(arrow_clear), 1);
    chk("hit_early", int'(correctHit), 0);
    tick(1);
    chk("hit_rise", int'(correctHit), 1);
    chk("hit_clear_once", int'(arrow_clear), 0);
    tick(1);
    chk("hit_hold", int'(correctHit), 1);
    tick(1);
    chk("hit_fall", int'(correctHit), 0);
    buttons = 4'b0000;
    tick(15);
    arrow_in_zone = 4'b0000;
    chk("hit_c_cnt", c_cnt, 1);
    chk("hit_i_cnt", i_cnt, 0);
    chk("hit_clr_cnt", clr_cnt, 1);
    chk("hit_clr_val", int'(clr_val), 1);
    chk("hit_shape", shape_err, 0);

    // Bounce rejection on lane 1
    b_c = c_cnt; b_i = i_cnt;
    for (int j = 0; j < 10; j++) begin
      buttons = (j % 2 == 0) ? 4'b0010 : 4'b0000;
      tick(2);
    end
    buttons = 4'b0000;
    tick(15);
    chk("bounce_c", c_cnt - b_c, 0);
    chk("bounce_i", i_cnt - b_i, 0);

    // Burst: three hits and one pass land together; miss drains first
    bs = seq.size(); b_clr = clr_cnt;
    arrow_in_zone = 4'b1111; buttons = 4'b0111;
    tick(6);
    arrow_passed = 4'b1000;
    tick(1);
    arrow_passed = 4'b0000;
    tick(1);
    chk("burst_first_inc", int'(incorrectHit), 1);
    chk("burst_first_cor", int'(correctHit), 0);
    tick(30);
    chk("burst_count", seq.size() - bs, 4);
    if (seq.size() >= bs + 4) begin
      ord = seq[bs] * 8 + seq[bs+1] * 4 + seq[bs+2] * 2 + seq[bs+3];
      chk("burst_order", ord, 8);
    end
    chk("burst_clr_cnt", clr_cnt - b_clr, 1);
    chk("burst_clr_val", int'(clr_val), 7);
    chk("burst_shape", shape_err, 0);
    buttons = 4'b0000; arrow_in_zone = 4'b0000;
    tick(15);

    // Hit and pass on lane 2 in the same cycle: hit wins
    b_c = c_cnt; b_i = i_cnt;
    arrow_in_zone = 4'b0100; buttons = 4'b0100;
    tick(6);
    arrow_passed = 4'b0100;
    tick(1);
    arrow_passed = 4'b0000;
    tick(15);
    chk("collide_c", c_cnt - b_c, 1);
    chk("collide_i", i_cnt - b_i, 0);
    buttons = 4'b0000; arrow_in_zone = 4'b0000;
    tick(15);

    // Saturation: 20 misses in 5 cycles; one taken by the FSM, 15 kept, 4 dropped
    b_i = i_cnt;
    arrow_passed = 4'b1111;
    tick(4);
    chk("sat_not_yet", int'(overflow), 0);
    tick(1);
    arrow_passed = 4'b0000;
    chk("sat_overflow", int'(overflow), 1);
    tick(90);
    chk("sat_pulses", i_cnt - b_i, 16);
    chk("sat_sticky", int'(overflow), 1);
    chk("sat_shape", shape_err, 0);

    // STATE_RESET mid-pulse with hits still pending
    b_c = c_cnt; b_i = i_cnt; b_shape = shape_err;
    arrow_in_zone = 4'b1111; buttons = 4'b1111;
    tick(8);
    chk("srst_pre", int'(correctHit), 1);
    state = ST_RESET;
    tick(1);
    chk("srst_cor_low", int'(correctHit), 0);
    chk("srst_inc_low", int'(incorrectHit), 0);
    chk("srst_ovf_clr", int'(overflow), 0);
    state = ST_MENU; buttons = 4'b0000; arrow_in_zone = 4'b0000;
    tick(30);
    chk("srst_c", c_cnt - b_c, 1);
    chk("srst_i", i_cnt - b_i, 0);
    chk("srst_cut", shape_err - b_shape, 1);
    chk("srst_ovf", int'(overflow), 0);

    // Asynchronous reset mid-HIGH drops the output without a clock edge
    b_c = c_cnt; b_i = i_cnt;
    state = ST_GAME; arrow_in_zone = 4'b0001; buttons = 4'b0001;
    tick(8);
    chk("arst_pre", int'(correctHit), 1);
    buttons = 4'b0000;
    tick(1);
    chk("arst_hold", int'(correctHit), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_drop", int'(correctHit), 0);
    chk("arst_clear", int'(arrow_clear), 0);
    state = ST_MENU; arrow_in_zone = 4'b0000;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    chk("arst_c", c_cnt - b_c, 1);
    chk("arst_i", i_cnt - b_i, 0);
    chk("arst_idle", int'(correctHit), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
